// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch target predictor with 2-bit counters and EX-stage resolution
// Ports: clk/rst_n (async active-low); F_PC -> Pred_Taken/Pred_Target (fetch lookup);
// Ex_* / Imm / AluResult (EX resolution) -> PC_Four, PC_Imm, Mispredict, Redirect_PC;
// Clear invalidates the table; Br_Count/Mp_Count are saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    F_PC,
    output logic               Pred_Taken,
    output logic [31:0]        Pred_Target,
    input  logic               Ex_Valid,
    input  logic               Ex_Branch,
    input  logic [PC_W-1:0]    Ex_PC,
    input  logic signed [31:0] Imm,
    input  logic [31:0]        AluResult,
    input  logic               Ex_PredTaken,
    input  logic [31:0]        Ex_PredTarget,
    input  logic               Clear,
    output logic [31:0]        PC_Four,
    output logic [31:0]        PC_Imm,
    output logic               Mispredict,
    output logic [31:0]        Redirect_PC,
    output logic [CNT_W-1:0]   Br_Count,
    output logic [CNT_W-1:0]   Mp_Count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];
    logic [IDX_W-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0]   f_tag, e_tag;
    logic               hit, e_hit, upd, actual_taken;

    assign f_idx = F_PC[IDX_W+1:2];
    assign f_tag = F_PC[PC_W-1:IDX_W+2];
    assign e_idx = Ex_PC[IDX_W+1:2];
    assign e_tag = Ex_PC[PC_W-1:IDX_W+2];

    // lookup reads registered state only, so an update is seen the cycle after its edge
    assign hit         = valid[f_idx] && tag[f_idx] == f_tag;
    assign Pred_Taken  = hit && ctr[f_idx][1];
    assign Pred_Target = Pred_Taken ? target[f_idx] : 32'(F_PC) + 32'd4;

    assign PC_Four      = 32'(Ex_PC) + 32'd4;
    assign PC_Imm       = 32'(Ex_PC) + 32'(Imm <<< 1);
    assign actual_taken = Ex_Branch && AluResult == 32'd1;
    assign upd          = Ex_Valid && Ex_Branch;
    assign e_hit        = valid[e_idx] && tag[e_idx] == e_tag;
    assign Mispredict   = upd && (actual_taken != Ex_PredTaken ||
                                  (actual_taken && Ex_PredTarget != PC_Imm));
    assign Redirect_PC  = actual_taken ? PC_Imm : PC_Four;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (Clear) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (upd) begin
            if (e_hit) begin
                ctr[e_idx] <= actual_taken ? (&ctr[e_idx] ? ctr[e_idx] : ctr[e_idx] + 2'd1)
                                           : (~|ctr[e_idx] ? ctr[e_idx] : ctr[e_idx] - 2'd1);
                if (actual_taken) target[e_idx] <= PC_Imm;
            end else if (actual_taken) begin
                valid[e_idx]  <= 1'b1;
                tag[e_idx]    <= e_tag;
                target[e_idx] <= PC_Imm;
                ctr[e_idx]    <= 2'b10;
            end
        end
    end

    // statistics ignore Clear and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Br_Count <= '0;
            Mp_Count <= '0;
        end else begin
            if (upd && !(&Br_Count)) Br_Count <= Br_Count + CNT_W'(1);
            if (Mispredict && !(&Mp_Count)) Mp_Count <= Mp_Count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vector bench for branch_predict_unit
module tb_branch_predict_unit;
    logic               clk = 1'b0;
    logic               rst_n;
    logic [8:0]         f_pc, ex_pc;
    logic               ex_valid, ex_branch, ex_pred_taken, clear;
    logic signed [31:0] imm;
    logic [31:0]        alu_result, ex_pred_target;
    logic               pred_taken, mispredict;
    logic [31:0]        pred_target, pc_four, pc_imm, redirect_pc, br_count, mp_count;
    logic               s_pred_taken, s_mispredict;
    logic [31:0]        s_pred_target, s_pc_four, s_pc_imm, s_redirect_pc;
    logic [1:0]         s_br_count, s_mp_count;
    int                 n_cmp = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .F_PC(f_pc), .Pred_Taken(pred_taken), .Pred_Target(pred_target),
        .Ex_Valid(ex_valid), .Ex_Branch(ex_branch), .Ex_PC(ex_pc), .Imm(imm), .AluResult(alu_result),
        .Ex_PredTaken(ex_pred_taken), .Ex_PredTarget(ex_pred_target), .Clear(clear),
        .PC_Four(pc_four), .PC_Imm(pc_imm), .Mispredict(mispredict), .Redirect_PC(redirect_pc),
        .Br_Count(br_count), .Mp_Count(mp_count)
    );

    // narrow-counter copy on the same stimulus, to reach counter saturation quickly
    branch_predict_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .F_PC(f_pc), .Pred_Taken(s_pred_taken), .Pred_Target(s_pred_target),
        .Ex_Valid(ex_valid), .Ex_Branch(ex_branch), .Ex_PC(ex_pc), .Imm(imm), .AluResult(alu_result),
        .Ex_PredTaken(ex_pred_taken), .Ex_PredTarget(ex_pred_target), .Clear(clear),
        .PC_Four(s_pc_four), .PC_Imm(s_pc_imm), .Mispredict(s_mispredict), .Redirect_PC(s_redirect_pc),
        .Br_Count(s_br_count), .Mp_Count(s_mp_count)
    );

    typedef struct {
        logic               ev, eb;
        logic [8:0]         epc;
        logic signed [31:0] imm;
        logic [31:0]        alu;
        logic               ept;
        logic [31:0]        eptgt;
        logic               clr;
        logic [8:0]         fpc;
        logic               pt;
        logic [31:0]        ptgt;
        logic               mp;
        logic [31:0]        rd, pimm;
        int                 br, mc;
    } vec_t;

    vec_t vec [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return v > 3 ? 3 : v;
    endfunction

    initial begin
        //          ev eb epc     imm alu ept eptgt  clr fpc      pt ptgt    mp rd            pimm          br  mc
        vec[0]  = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h010,  0, 'h14,   0, 'h4,          'h0,          0,  0};
        vec[1]  = '{1, 1, 9'h010, 8,  1,  0,  0,     0,  9'h010,  0, 'h14,   1, 'h20,         'h20,         0,  0};
        vec[2]  = '{1, 1, 9'h010, 8,  0,  1,  'h20,  0,  9'h010,  1, 'h20,   1, 'h14,         'h20,         1,  1};
        vec[3]  = '{1, 1, 9'h010, 8,  0,  0,  'h14,  0,  9'h010,  0, 'h14,   0, 'h14,         'h20,         2,  2};
        vec[4]  = '{0, 1, 9'h004, -4, 1,  0,  0,     0,  9'h010,  0, 'h14,   0, 'hFFFFFFFC,   'hFFFFFFFC,   3,  2};
        vec[5]  = '{1, 1, 9'h050, 2,  1,  0,  0,     0,  9'h050,  0, 'h54,   1, 'h54,         'h54,         3,  2};
        vec[6]  = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h050,  1, 'h54,   0, 'h4,          'h0,          4,  3};
        vec[7]  = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h010,  0, 'h14,   0, 'h4,          'h0,          4,  3};
        vec[8]  = '{1, 1, 9'h050, 2,  1,  1,  'h60,  1,  9'h050,  1, 'h54,   1, 'h54,         'h54,         4,  3};
        vec[9]  = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h050,  0, 'h54,   0, 'h4,          'h0,          5,  4};
        vec[10] = '{1, 1, 9'h050, 2,  1,  0,  0,     0,  9'h050,  0, 'h54,   1, 'h54,         'h54,         5,  4};
        vec[11] = '{1, 1, 9'h050, 2,  1,  1,  'h54,  0,  9'h050,  1, 'h54,   0, 'h54,         'h54,         6,  5};
        vec[12] = '{1, 1, 9'h050, 2,  1,  1,  'h54,  0,  9'h050,  1, 'h54,   0, 'h54,         'h54,         7,  5};
        vec[13] = '{1, 1, 9'h050, 2,  0,  1,  'h54,  0,  9'h050,  1, 'h54,   1, 'h54,         'h54,         8,  5};
        vec[14] = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h050,  1, 'h54,   0, 'h4,          'h0,          9,  6};
        vec[15] = '{1, 1, 9'h050, 2,  0,  1,  'h54,  0,  9'h050,  1, 'h54,   1, 'h54,         'h54,         9,  6};
        vec[16] = '{1, 1, 9'h050, 2,  0,  0,  'h54,  0,  9'h050,  0, 'h54,   0, 'h54,         'h54,         10, 7};
        vec[17] = '{1, 1, 9'h050, 2,  0,  0,  'h54,  0,  9'h050,  0, 'h54,   0, 'h54,         'h54,         11, 7};
        vec[18] = '{1, 1, 9'h050, 2,  1,  0,  0,     0,  9'h050,  0, 'h54,   1, 'h54,         'h54,         12, 7};
        vec[19] = '{0, 0, 9'h000, 0,  0,  0,  0,     0,  9'h050,  0, 'h54,   0, 'h4,          'h0,          13, 8};

        rst_n = 1'b0; f_pc = 9'h010; ex_valid = 0; ex_branch = 0; ex_pc = 0; imm = 0;
        alu_result = 0; ex_pred_taken = 0; ex_pred_target = 0; clear = 0;
        #12;
        chk("reset_pred_taken", 32'(pred_taken), 0);
        chk("reset_pred_target", pred_target, 32'h14);
        chk("reset_br_count", br_count, 0);
        chk("reset_mp_count", mp_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            ex_valid = vec[i].ev; ex_branch = vec[i].eb; ex_pc = vec[i].epc; imm = vec[i].imm;
            alu_result = vec[i].alu; ex_pred_taken = vec[i].ept; ex_pred_target = vec[i].eptgt;
            clear = vec[i].clr; f_pc = vec[i].fpc;
            #1;
            chk($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(vec[i].pt));
            chk($sformatf("v%0d_pred_target", i), pred_target, vec[i].ptgt);
            chk($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(vec[i].mp));
            chk($sformatf("v%0d_redirect", i), redirect_pc, vec[i].rd);
            chk($sformatf("v%0d_pc_imm", i), pc_imm, vec[i].pimm);
            chk($sformatf("v%0d_pc_four", i), pc_four, 32'(vec[i].epc) + 32'd4);
            chk($sformatf("v%0d_br_count", i), br_count, 32'(vec[i].br));
            chk($sformatf("v%0d_mp_count", i), mp_count, 32'(vec[i].mc));
            chk($sformatf("v%0d_sat_br", i), 32'(s_br_count), 32'(sat3(vec[i].br)));
            chk($sformatf("v%0d_sat_mp", i), 32'(s_mp_count), 32'(sat3(vec[i].mc)));
            @(posedge clk); #2;
        end

        // reset asserted mid-cycle with an update pending: the update is discarded
        ex_valid = 1; ex_branch = 1; ex_pc = 9'h010; imm = 8; alu_result = 1;
        ex_pred_taken = 0; ex_pred_target = 0; clear = 0; f_pc = 9'h010;
        rst_n = 1'b0;
        #1;
        chk("midrst_br_count", br_count, 0);
        chk("midrst_mp_count", mp_count, 0);
        chk("midrst_pred_taken", 32'(pred_taken), 0);
        chk("midrst_pred_target", pred_target, 32'h14);
        @(posedge clk); #2;
        chk("midrst_edge_br_count", br_count, 0);
        chk("midrst_edge_pred_taken", 32'(pred_taken), 0);
        rst_n = 1'b1;
        #1;
        chk("postrst_idle_br_count", br_count, 0);
        @(posedge clk); #2;
        ex_valid = 0; ex_branch = 0;
        #1;
        chk("postrst_br_count", br_count, 1);
        chk("postrst_mp_count", mp_count, 1);
        chk("postrst_pred_taken", 32'(pred_taken), 1);
        chk("postrst_pred_target", pred_target, 32'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the PC width in bits; legal range is PC_W >= IDX_W+3.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning the number of predictor entries; it SHALL be a power of two >= 2, with IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of each statistics counter.
REQ-004 Ports, in this order: name, direction, width, meaning.
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- F_PC, in, PC_W: fetch-stage PC.
- Pred_Taken, out, 1: fetch prediction.
- Pred_Target, out, 32: predicted next PC.
- Ex_Valid, in, 1: the EX-stage instruction is valid (not a bubble or flushed).
- Ex_Branch, in, 1: the EX instruction is a conditional branch.
- Ex_PC, in, PC_W: PC of the EX instruction.
- Imm, in, 32 signed: branch offset in halfwords.
- AluResult, in, 32: equals 1 when the branch condition holds.
- Ex_PredTaken, in, 1: prediction carried down the pipe with the EX instruction.
- Ex_PredTarget, in, 32: predicted target carried down the pipe.
- Clear, in, 1: synchronous invalidate-all.
- PC_Four, out, 32: Ex_PC+4.
- PC_Imm, out, 32: branch target.
- Mispredict, out, 1: the pipeline must flush.
- Redirect_PC, out, 32: the correct next PC.
- Br_Count, out, CNT_W: number of resolved branches.
- Mp_Count, out, CNT_W: number of mispredictions.

Function
REQ-005 Each entry SHALL hold: valid (1 bit), tag (bits PC_W-1 down to IDX_W+2), target (32 bits) and a 2-bit saturating counter; index = PC bits [IDX_W+1:2].
REQ-006 Lookup SHALL be combinational on F_PC against registered state.
- Hit = valid && tag match.
- Pred_Taken = Hit && ctr[1].
- Pred_Target = target when Pred_Taken, else zero-extended F_PC+4.
REQ-007 Arithmetic SHALL be:
- PC_Four = zext(Ex_PC)+4.
- PC_Imm = zext(Ex_PC) + (Imm <<< 1), 32-bit, wrapping modulo 2^32.
REQ-008 Actual_Taken SHALL equal Ex_Branch && (AluResult == 1).
REQ-009 Mispredict SHALL be combinational and equal Ex_Valid && Ex_Branch && ((Actual_Taken != Ex_PredTaken) || (Actual_Taken && Ex_PredTarget != PC_Imm)).
REQ-010 Redirect_PC SHALL equal PC_Imm when Actual_Taken, else PC_Four; it is valid regardless of Mispredict.
REQ-011 On a clock edge with Ex_Valid && Ex_Branch, the entry at Ex_PC's index SHALL update as follows.
- Tag hit: the counter increments (saturating at 11) if taken, decrements (saturating at 00) if not taken, and target <= PC_Imm if taken.
- Tag miss and taken: valid <= 1, tag written, target <= PC_Imm, ctr <= 10 (the previous occupant is replaced).
- Tag miss and not taken: no change.
REQ-012 A table update SHALL become visible to lookup on the cycle after the edge; a same-cycle lookup of the index being updated SHALL return the old contents (no bypass).
REQ-013 Br_Count SHALL increment on every edge with Ex_Valid && Ex_Branch, and Mp_Count SHALL increment on every edge with Mispredict; both saturate at all-ones and never wrap.
REQ-014 Clear SHALL clear all valid bits and reset all counters to 01 at the edge, takes priority over a simultaneous update, and SHALL NOT affect the statistics counters.
REQ-015 With Ex_Valid=0, the block SHALL change no state and Mispredict SHALL be 0; PC_Four and PC_Imm still follow Ex_PC and Imm.

Reset
REQ-016 When rst_n is low, asynchronously: all valid bits = 0, all counters = 01, targets and tags = 0, Br_Count = 0, Mp_Count = 0.
REQ-017 While rst_n is low, Pred_Taken SHALL be 0 and Pred_Target SHALL be F_PC+4.
REQ-018 Assertion of rst_n mid-operation SHALL discard any update that would occur at that edge; the first update SHALL occur at the first rising edge after deassertion.

Verification
REQ-019 The bench SHALL cover these scenarios:
- After reset, F_PC=0x010 -> Pred_Taken=0, Pred_Target=0x14.
- Ex_PC=0x010, Imm=8, AluResult=1, Ex_PredTaken=0 -> Mispredict=1, Redirect_PC=0x20; next cycle F_PC=0x010 -> Pred_Taken=1, Pred_Target=0x20; Br_Count=1, Mp_Count=1.
- The same branch resolved not-taken twice with a correct prediction on the second resolution -> counter 10->01->00, Pred_Taken=0; the first resolution mispredicts (Redirect_PC=0x14), the second does not.
- Imm=-4 at Ex_PC=0x004 -> PC_Imm=0xFFFFFFFC, with no X and no wrap error.
- Aliasing: PC 0x010 and PC 0x050 (same index, different tag) -> 0x050 taken replaces the entry, and 0x010 then misses.
- Simultaneous Clear and update -> entry invalid next cycle, while statistics still increment; an Mp_Count forced to all-ones holds at all-ones.
